// File: rtl/ram_read_scanner.sv
// ram_read_scanner: owns the read port of a small dual-port RAM. It walks the
// read address on a programmable tick (or on a step pulse), waits out the
// RAM's registered-read latency, then presents a stable address/data pair for
// display while re-reading the same address every clock so writes from the
// other port show up live.
module ram_read_scanner #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    // Prescaler only ever holds 0..TICK_DIV-1; wait counter holds 0..RD_LAT.
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(RD_LAT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        SHOW
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [ADDR_W-1:0] disp_addr_next;
    logic [DATA_W-1:0] disp_data_next;
    logic              disp_valid_next;
    logic              wrap_next;
    logic              advance;

    // Next-state and next-register values; everything holds unless a state says otherwise.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        wait_cnt_next   = wait_cnt;
        rd_addr_next    = rd_addr;
        disp_addr_next  = disp_addr;
        disp_data_next  = disp_data;
        disp_valid_next = disp_valid;
        wrap_next       = 1'b0;
        // A step coinciding with the tick still yields a single increment.
        advance         = step | (enable & (cnt == CNT_LAST));

        case (state)
            ISSUE: begin
                // rd_addr was just updated; give the RAM one clock to sample it.
                state_next    = WAIT;
                wait_cnt_next = WAIT_LOAD;
            end

            WAIT: begin
                if (wait_cnt == WAIT_ONE) begin
                    // Last latency clock: q now belongs to rd_addr.
                    disp_data_next  = rd_data;
                    disp_addr_next  = rd_addr;
                    disp_valid_next = 1'b1;
                    cnt_next        = '0;
                    wait_cnt_next   = '0;
                    state_next      = SHOW;
                end else begin
                    wait_cnt_next = wait_cnt - WAIT_ONE;
                end
            end

            SHOW: begin
                // Address is stable here, so keep refreshing the shown data.
                disp_data_next = rd_data;
                if (advance) begin
                    rd_addr_next = rd_addr + ADDR_ONE;
                    wrap_next    = &rd_addr;
                    cnt_next     = '0;
                    state_next   = ISSUE;
                end else if (enable) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ISSUE;
            cnt        <= '0;
            wait_cnt   <= '0;
            rd_addr    <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wait_cnt   <= wait_cnt_next;
            rd_addr    <= rd_addr_next;
            disp_addr  <= disp_addr_next;
            disp_data  <= disp_data_next;
            disp_valid <= disp_valid_next;
            wrap       <= wrap_next;
        end
    end

endmodule

// File: doc/ram_read_scanner.md
Name: ram_read_scanner

Overview:
- Read-side sequencer for the lab's 32x3 dual-port RAM.
- The switch-driven write port fills memory; this block owns the read port. It steps the read address automatically, on a programmable tick, and accounts for the RAM's registered-read latency.
- It presents a stable address/data pair for the HEX display logic.
- While dwelling on an address it keeps re-reading, so writes from the other port appear live.

Parameters:
- ADDR_W, 5, read address width (RAM depth 2^ADDR_W).
- DATA_W, 3, RAM word width.
- TICK_DIV, 50_000_000, SHOW-state clocks per automatic address advance (1 s at 50 MHz). Must be >= 1.
- RD_LAT, 1, RAM read latency in clocks, from address sampled to q valid. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = auto-advance on tick; 0 = paused (dwell, refresh continues).
- step  in  1  single-cycle advance request; caller supplies a synchronized one-clock pulse.
- rd_data  in  DATA_W  RAM read-port q.
- rd_addr  out  ADDR_W  RAM read-port address; registered.
- disp_addr  out  ADDR_W  address whose data is shown.
- disp_data  out  DATA_W  data shown for disp_addr.
- disp_valid  out  1  0 until the first capture after reset, then 1.
- wrap  out  1  one-clock pulse when rd_addr advances from 2^ADDR_W-1 to 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=ISSUE.
  - rd_addr, disp_addr, disp_data, prescaler cnt and wait counter all 0.
  - disp_valid=0, wrap=0.
  - Reset overrides everything, in any state (mid-WAIT or mid-SHOW included).
- ISSUE (1 clock):
  - rd_addr is held stable.
  - Next state is WAIT, with the wait counter loaded to RD_LAT.
- WAIT (RD_LAT clocks):
  - The wait counter decrements each clock.
  - On the edge ending the last WAIT clock: disp_data<=rd_data, disp_addr<=rd_addr, disp_valid<=1, cnt<=0, state=SHOW.
  - With RD_LAT=1, a new rd_addr reaches disp_addr/disp_data 2 clocks after rd_addr changes.
- SHOW:
  - Every clock: disp_data<=rd_data (live refresh). disp_addr is unchanged.
  - advance = step OR (enable AND cnt==TICK_DIV-1).
  - If enable and not advance: cnt<=cnt+1.
  - If not enable: cnt holds.
  - On advance:
    - rd_addr<=rd_addr+1, modulo 2^ADDR_W.
    - cnt<=0, state=ISSUE.
    - wrap<=1 for that one clock if the old rd_addr was all ones.
  - step and tick in the same clock produce a single increment.
- step in ISSUE or WAIT is ignored (not queued).
- enable deasserted mid-count freezes cnt. Reasserting resumes from the frozen value; there is no restart.
- Auto-advance period = TICK_DIV + RD_LAT + 1 clocks per address.
  - TICK_DIV=1 gives RD_LAT+2 clocks per address.
- wrap is 0 in all other clocks.
- disp_valid never returns to 0 except via reset.
- No combinational path from any input to any output.

Test Plan:
(Bench: TICK_DIV=4, RD_LAT=1, behavioural 32x3 RAM with registered address, preloaded mem[a]=a%8, second port writable by bench.)
1. reset=0 for 2 clocks -> all outputs 0. Release with enable=1 -> disp_valid=1, disp_addr=0, disp_data=0 after edge 2; rd_addr=1 after edge 6; disp_addr=1, disp_data=1 after edge 8.
2. Run to address 31 -> disp_addr=31, disp_data=7; next advance gives rd_addr=0 with wrap=1 for exactly one clock; disp_addr=0 two clocks later.
3. enable=0 while in SHOW at address 5, for 20 clocks -> rd_addr and disp_addr stay 5, cnt frozen. One-clock step -> rd_addr=6 next clock; disp_addr=6, disp_data=6 two clocks after that.
4. Paused at address 3, bench writes 5 to mem[3] via the other port -> disp_data becomes 5 within RD_LAT+1 clocks; disp_addr stays 3; wrap stays 0.
5. Pulse reset=0 for one clock while in WAIT -> next edge: rd_addr=0, disp_valid=0, wrap=0, state ISSUE. Normal sequence restarts from address 0.
6. step asserted on the clock where cnt==3 with enable=1 -> rd_addr increments by exactly 1. step asserted during ISSUE -> no increment.
